// File: rtl/lsu_dmem_ctrl_if.sv
// Core <-> data-memory controller bus: request handshake, load response, stall and fault.
// Combinational bundle only; all timing lives in lsu_dmem_ctrl.
// The core drives req_* while req_ready is high; responses cannot be backpressured.
interface lsu_dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_daddr;
    logic [31:0] resp_drdata;
    logic [2:0]  resp_funct3;
    logic        busy;
    logic        fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_daddr, resp_drdata, resp_funct3, busy, fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_daddr, resp_drdata, resp_funct3, busy, fault
    );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Data-memory controller: one load/store at a time into a byte-enabled word RAM (MISALIGN_TRAP_EN adds misalignment faults).
// Latency: resp_valid WAIT_CYCLES+2 cycles after acceptance (1 cycle for a trapped misaligned access).
// Backpressure: req_ready only in IDLE, busy elsewhere; the one-cycle response is never stalled.
module lsu_dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    lsu_dmem_ctrl_if.slave bus
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  wait_cnt;
    logic        cap_we;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] rd_q;
    logic [AW-1:0] ram_idx;
    logic [3:0]  wr_be;
    logic [31:0] wr_dat;
    logic        req_mis;
    logic [31:0] mem [DEPTH_WORDS];

`ifdef MISALIGN_TRAP_EN
    logic fault_q;

    always_comb begin
        req_mis = (((bus.req_funct3 == 3'b001) || (bus.req_funct3 == 3'b101)) && bus.req_addr[0])
                || ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (rst)
            fault_q <= 1'b0;
        else if (state == S_IDLE && bus.req_valid)
            fault_q <= req_mis;
    end

    assign bus.fault = fault_q && (state == S_RESP);
`else
    assign req_mis   = 1'b0;
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (req_mis)
                        state_n = S_RESP;
                    else if (WAIT_CYCLES == 0)
                        state_n = S_ACCESS;
                    else
                        state_n = S_WAIT;
                end
            end
            S_WAIT:   if (wait_cnt == 4'd0) state_n = S_ACCESS;
            S_ACCESS: state_n = S_RESP;
            S_RESP:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_f3    <= 3'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            wait_cnt  <= 4'd0;
            rd_q      <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        cap_we    <= bus.req_we;
                        cap_f3    <= bus.req_funct3;
                        cap_addr  <= bus.req_addr;
                        cap_wdata <= bus.req_wdata;
                        wait_cnt  <= WAIT_INIT;
                        if (req_mis)
                            rd_q <= 32'd0;
                    end
                end
                S_WAIT:   if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                // Stores clear the read register so their response carries zero data.
                S_ACCESS: rd_q <= cap_we ? 32'd0 : mem[ram_idx];
                default:  ;
            endcase
        end
    end

    assign ram_idx = cap_addr[AW+1:2];

    always_comb begin
        wr_be  = 4'b0000;
        wr_dat = cap_wdata;
        case (cap_f3)
            3'b000: begin
                wr_be  = 4'b0001 << cap_addr[1:0];
                wr_dat = {4{cap_wdata[7:0]}};
            end
            3'b001: begin
                wr_be  = 4'b0011 << {cap_addr[1], 1'b0};
                wr_dat = {2{cap_wdata[15:0]}};
            end
            3'b010:  wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // A reset landing on the ACCESS edge suppresses the write so a store is all-or-nothing.
    always_ff @(posedge clk) begin
        if (!rst && state == S_ACCESS && cap_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b])
                    mem[ram_idx][8*b +: 8] <= wr_dat[8*b +: 8];
            end
        end
    end

    assign bus.req_ready   = (state == S_IDLE);
    assign bus.busy        = (state != S_IDLE);
    assign bus.resp_valid  = (state == S_RESP);
    assign bus.resp_daddr  = cap_addr;
    assign bus.resp_funct3 = cap_f3;
    assign bus.resp_drdata = rd_q;
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl with default parameters (1024 words, 2 wait states).
module tb_lsu_dmem_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    lsu_dmem_ctrl_if bus ();

    lsu_dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and check latency, response fields and the idle cycle after.
    task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic [31:0] exp_rd, input logic exp_fault);
        int lat;
        lat = -1;
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(negedge clk);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'hA5A5_A5A5;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, ".busy1"}, 32'(bus.busy), 32'd1);
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        if (lat > 0) begin
            chk({tag, ".drdata"}, bus.resp_drdata, exp_rd);
            chk({tag, ".daddr"}, bus.resp_daddr, a);
            chk({tag, ".funct3"}, 32'(bus.resp_funct3), 32'(f3));
            chk({tag, ".fault"}, 32'(bus.fault), 32'(exp_fault));
            chk({tag, ".busy_resp"}, 32'(bus.busy), 32'd1);
            @(negedge clk);
            chk({tag, ".pulse"}, 32'(bus.resp_valid), 32'd0);
            chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
            chk({tag, ".hold"}, bus.resp_drdata, exp_rd);
            chk({tag, ".fault_off"}, 32'(bus.fault), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst            = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0044;
        bus.req_wdata  = 32'h9999_9999;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(bus.req_ready), 32'd1);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst.fault", 32'(bus.fault), 32'd0);
        chk("rst.daddr", bus.resp_daddr, 32'd0);
        chk("rst.drdata", bus.resp_drdata, 32'd0);
        chk("rst.funct3", 32'(bus.resp_funct3), 32'd0);
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rst.nocapture_busy", 32'(bus.busy), 32'd0);
        chk("rst.nocapture_addr", bus.resp_daddr, 32'd0);

        xact("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 4, 32'h0, 1'b0);
        xact("lw10a", 1'b0, 3'b010, 32'h10, 32'h0, 4, 32'hDEAD_BEEF, 1'b0);
        xact("sb11", 1'b1, 3'b000, 32'h11, 32'h0000_00AA, 4, 32'h0, 1'b0);
        xact("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 4, 32'hDEAD_AAEF, 1'b0);
        xact("sh12", 1'b1, 3'b001, 32'h12, 32'h0000_1234, 4, 32'h0, 1'b0);
        xact("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 4, 32'h1234_AAEF, 1'b0);
        xact("lbu11", 1'b0, 3'b100, 32'h11, 32'h0, 4, 32'h1234_AAEF, 1'b0);

        // Store interrupted by reset in its first WAIT cycle.
        xact("sw20", 1'b1, 3'b010, 32'h20, 32'h0, 4, 32'h0, 1'b0);
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h5555_5555;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst           = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        chk("rstwait.no_resp", 32'(pulses), 32'd0);
        chk("rstwait.idle", 32'(bus.busy), 32'd0);
        xact("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 4, 32'h0, 1'b0);

        xact("sw1000", 1'b1, 3'b010, 32'h1000, 32'h0BAD_F00D, 4, 32'h0, 1'b0);
        xact("lw0a", 1'b0, 3'b010, 32'h0, 32'h0, 4, 32'h0BAD_F00D, 1'b0);
        xact("st011", 1'b1, 3'b011, 32'h0, 32'hFFFF_FFFF, 4, 32'h0, 1'b0);
        xact("lw0b", 1'b0, 3'b010, 32'h0, 32'h0, 4, 32'h0BAD_F00D, 1'b0);

`ifdef MISALIGN_TRAP_EN
        xact("mis_lw13", 1'b0, 3'b010, 32'h13, 32'h0, 1, 32'h0, 1'b1);
        xact("mis_sh13", 1'b1, 3'b001, 32'h13, 32'h0000_FFFF, 1, 32'h0, 1'b1);
        xact("mis_lw10", 1'b0, 3'b010, 32'h10, 32'h0, 4, 32'h1234_AAEF, 1'b0);
`else
        xact("mis_sh13", 1'b1, 3'b001, 32'h13, 32'h0000_5678, 4, 32'h0, 1'b0);
        xact("mis_lw10", 1'b0, 3'b010, 32'h10, 32'h0, 4, 32'h5678_AAEF, 1'b0);
        xact("mis_lw13", 1'b0, 3'b010, 32'h13, 32'h0, 4, 32'h5678_AAEF, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
